// File: rtl/td4_cpu.sv
// rtl/td4_cpu.sv - single-cycle TD4-style accumulator CPU; HLT opcode enabled by `TD4_CPU_HALT_EN
module td4_cpu #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4,
    parameter int RST_PC = 0
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [DATA_W+3:0] data,
    input  logic [DATA_W-1:0] switch,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] led,
    output logic              halted
);
    localparam logic [ADDR_W-1:0] RST_ADDR = ADDR_W'(RST_PC);

    typedef enum logic [3:0] {
        OP_ADD_A  = 4'b0000,
        OP_MOV_AB = 4'b0001,
        OP_IN_A   = 4'b0010,
        OP_MOV_AI = 4'b0011,
        OP_MOV_BA = 4'b0100,
        OP_ADD_B  = 4'b0101,
        OP_IN_B   = 4'b0110,
        OP_MOV_BI = 4'b0111,
        OP_HLT    = 4'b1000,
        OP_OUT_B  = 4'b1001,
        OP_OUT_I  = 4'b1011,
        OP_JNC    = 4'b1110,
        OP_JMP    = 4'b1111
    } opcode_t;

    logic [ADDR_W-1:0] pc, pc_inc, pc_nxt;
    logic [DATA_W-1:0] reg_a, reg_b, led_q;
    logic [DATA_W-1:0] a_nxt, b_nxt, led_nxt;
    logic              carry, c_nxt;
    logic              run;
    opcode_t           opcode;
    logic [DATA_W-1:0] im, src;
    logic [ADDR_W-1:0] im_addr;
    logic [DATA_W:0]   sum;

    assign opcode  = opcode_t'(data[DATA_W+3:DATA_W]);
    assign im      = data[DATA_W-1:0];
    assign im_addr = im[ADDR_W-1:0];
    assign pc_inc  = pc + ADDR_W'(1);
    assign src     = (opcode == OP_ADD_B) ? reg_b : reg_a;
    assign sum     = {1'b0, src} + {1'b0, im};

    assign addr = pc;
    assign led  = led_q;

`ifdef TD4_CPU_HALT_EN
    logic halt_req;
    logic halted_q;

    // Sticky until reset; freezes all architectural state via run.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            halted_q <= 1'b0;
        end else if (halt_req) begin
            halted_q <= 1'b1;
        end
    end

    assign run    = ~halted_q;
    assign halted = halted_q;
`else
    assign run    = 1'b1;
    assign halted = 1'b0;
`endif

    always_comb begin
        pc_nxt  = pc_inc;
        a_nxt   = reg_a;
        b_nxt   = reg_b;
        c_nxt   = 1'b0;
        led_nxt = led_q;
`ifdef TD4_CPU_HALT_EN
        halt_req = 1'b0;
`endif
        case (opcode)
            OP_ADD_A: begin
                a_nxt = sum[DATA_W-1:0];
                c_nxt = sum[DATA_W];
            end
            OP_ADD_B: begin
                b_nxt = sum[DATA_W-1:0];
                c_nxt = sum[DATA_W];
            end
            OP_MOV_AI: a_nxt   = im;
            OP_MOV_BI: b_nxt   = im;
            OP_MOV_AB: a_nxt   = reg_b;
            OP_MOV_BA: b_nxt   = reg_a;
            OP_IN_A:   a_nxt   = switch;
            OP_IN_B:   b_nxt   = switch;
            OP_OUT_B:  led_nxt = reg_b;
            OP_OUT_I:  led_nxt = im;
            OP_JMP:    pc_nxt  = im_addr;
            // Carry is tested here, before the default clear lands on the edge.
            OP_JNC: begin
                if (!carry) pc_nxt = im_addr;
            end
`ifdef TD4_CPU_HALT_EN
            OP_HLT:    halt_req = 1'b1;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            pc    <= RST_ADDR;
            reg_a <= '0;
            reg_b <= '0;
            carry <= 1'b0;
            led_q <= '0;
        end else if (run) begin
            pc    <= pc_nxt;
            reg_a <= a_nxt;
            reg_b <= b_nxt;
            carry <= c_nxt;
            led_q <= led_nxt;
        end
    end

endmodule

// File: tb/tb_td4_cpu.sv
// tb/tb_td4_cpu.sv - directed scoreboard bench for td4_cpu with a 16-entry ROM model
module tb_td4_cpu;
    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic [7:0] data;
    logic [3:0] switch;
    logic [3:0] addr;
    logic [3:0] led;
    logic       halted;

    logic [7:0] rom [16];

    typedef struct packed {
        logic [3:0] addr;
        logic [3:0] led;
        logic       halted;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

`ifdef TD4_CPU_HALT_EN
    localparam logic HALT_ON = 1'b1;
`else
    localparam logic HALT_ON = 1'b0;
`endif

    td4_cpu #(.DATA_W(4), .ADDR_W(4), .RST_PC(0)) dut (
        .clk    (clk),
        .n_rst  (n_rst),
        .data   (data),
        .switch (switch),
        .addr   (addr),
        .led    (led),
        .halted (halted)
    );

    assign data = rom[addr];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_outputs(input string tag, input exp_t e);
        chk({tag, ".addr"}, {4'h0, addr}, {4'h0, e.addr});
        chk({tag, ".led"}, {4'h0, led}, {4'h0, e.led});
        chk({tag, ".halted"}, {7'h0, halted}, {7'h0, e.halted});
    endtask

    // Expected outputs are queued before the edge that produces them.
    task automatic step(input string tag, input logic [3:0] a, input logic [3:0] l, input logic h);
        exp_t e;
        sbq.push_back('{addr: a, led: l, halted: h});
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        cmp_outputs(tag, e);
    endtask

    task automatic now(input string tag, input logic [3:0] a, input logic [3:0] l, input logic h);
        exp_t e;
        sbq.push_back('{addr: a, led: l, halted: h});
        e = sbq.pop_front();
        cmp_outputs(tag, e);
    endtask

    task automatic enter_reset();
        @(negedge clk);
        n_rst = 1'b0;
        for (int i = 0; i < 16; i++) rom[i] = 8'hA0;
    endtask

    task automatic leave_reset();
        @(negedge clk);
        n_rst = 1'b1;
    endtask

    initial begin
        switch = 4'h0;
        for (int i = 0; i < 16; i++) rom[i] = 8'hA0;

        // Reset state after a couple of edges held in reset
        repeat (2) @(posedge clk);
        #1;
        now("rst_init", 4'h0, 4'h0, 1'b0);

        // Asynchronous reset mid-run
        rom[0] = 8'hB5;
        leave_reset();
        step("run1", 4'h1, 4'h5, 1'b0);
        step("run2", 4'h2, 4'h5, 1'b0);
        step("run3", 4'h3, 4'h5, 1'b0);
        step("run4", 4'h4, 4'h5, 1'b0);
        step("run5", 4'h5, 4'h5, 1'b0);
        #2;
        n_rst = 1'b0;
        #1;
        now("rst_async", 4'h0, 4'h0, 1'b0);
        leave_reset();
        step("rst_restart", 4'h1, 4'h5, 1'b0);

        // ADD with carry, JNC not taken then taken
        enter_reset();
        rom[0] = 8'h33; rom[1] = 8'h0E; rom[2] = 8'hE0; rom[3] = 8'hE0;
        leave_reset();
        step("carry_mov", 4'h1, 4'h0, 1'b0);
        step("carry_add", 4'h2, 4'h0, 1'b0);
        step("jnc_not_taken", 4'h3, 4'h0, 1'b0);
        step("jnc_taken", 4'h0, 4'h0, 1'b0);

        // A wraps to 1, no-carry ADD lets JNC jump, jump-to-self loop
        enter_reset();
        rom[0] = 8'h33; rom[1] = 8'h0E; rom[2] = 8'h40; rom[3] = 8'h90;
        rom[4] = 8'h02; rom[5] = 8'hE8; rom[8] = 8'h40; rom[9] = 8'h90;
        rom[10] = 8'hFA;
        leave_reset();
        step("wrap_e1", 4'h1, 4'h0, 1'b0);
        step("wrap_e2", 4'h2, 4'h0, 1'b0);
        step("wrap_e3", 4'h3, 4'h0, 1'b0);
        step("wrap_out", 4'h4, 4'h1, 1'b0);
        step("add_nc", 4'h5, 4'h1, 1'b0);
        step("jnc_nc_taken", 4'h8, 4'h1, 1'b0);
        step("movba", 4'h9, 4'h1, 1'b0);
        step("out3", 4'hA, 4'h3, 1'b0);
        step("self_loop", 4'hA, 4'h3, 1'b0);

        // Register moves and I/O; switch changes after the first IN
        enter_reset();
        switch = 4'hA;
        rom[0] = 8'h20; rom[1] = 8'h40; rom[2] = 8'h51; rom[3] = 8'h90;
        rom[4] = 8'h77; rom[5] = 8'h10; rom[6] = 8'h60; rom[7] = 8'h90;
        rom[8] = 8'h40; rom[9] = 8'h90; rom[10] = 8'hFA;
        leave_reset();
        step("in_a", 4'h1, 4'h0, 1'b0);
        switch = 4'h3;
        step("mov_ba", 4'h2, 4'h0, 1'b0);
        step("add_b", 4'h3, 4'h0, 1'b0);
        step("out_b", 4'h4, 4'hB, 1'b0);
        step("mov_bi", 4'h5, 4'hB, 1'b0);
        step("mov_ab", 4'h6, 4'hB, 1'b0);
        step("in_b", 4'h7, 4'hB, 1'b0);
        step("out_in_b", 4'h8, 4'h3, 1'b0);
        step("mov_ba2", 4'h9, 4'h3, 1'b0);
        step("out_a_via_b", 4'hA, 4'h7, 1'b0);

        // OUT Im / JMP ping-pong
        enter_reset();
        rom[0] = 8'hB5; rom[1] = 8'hF0;
        leave_reset();
        step("out_im", 4'h1, 4'h5, 1'b0);
        step("jmp0_a", 4'h0, 4'h5, 1'b0);
        step("out_im2", 4'h1, 4'h5, 1'b0);
        step("jmp0_b", 4'h0, 4'h5, 1'b0);

        // PC wrap through sixteen NOP-class opcodes
        enter_reset();
        for (int i = 0; i < 16; i++) begin
            case (i % 3)
                0:       rom[i] = {4'hA, 4'(i)};
                1:       rom[i] = {4'hC, 4'(i)};
                default: rom[i] = {4'hD, 4'(i)};
            endcase
        end
        leave_reset();
        for (int i = 1; i <= 17; i++) begin
            step($sformatf("pc_wrap%0d", i), 4'(i), 4'h0, 1'b0);
        end

        // HLT handling, build-dependent
        enter_reset();
        rom[0] = 8'h37; rom[1] = 8'h80; rom[2] = 8'h40; rom[3] = 8'h90; rom[4] = 8'hF4;
        leave_reset();
        step("hlt_mov", 4'h1, 4'h0, 1'b0);
        step("hlt_exec", 4'h2, 4'h0, HALT_ON);
        for (int i = 0; i < 10; i++) begin
            if (HALT_ON) begin
                rom[2] = 8'($urandom);
                step($sformatf("halt_hold%0d", i), 4'h2, 4'h0, 1'b1);
            end else begin
                rom[0] = 8'($urandom);
                if (i == 0) step("nohalt_mov", 4'h3, 4'h0, 1'b0);
                else step($sformatf("nohalt_run%0d", i), 4'h4, 4'h7, 1'b0);
            end
        end
        #2;
        n_rst = 1'b0;
        #1;
        now("hlt_reset", 4'h0, 4'h0, 1'b0);
        leave_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
